// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional divider datapath is controlled by the MULDIV_DIV_EN macro.
package muldiv_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFinish
    } state_e;

    // Absolute value for signed operands, pass-through for unsigned ones.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// Single-iteration combinational datapath for the multiply/divide unit.
// Multiply: conditional add of the multiplicand into the upper half, then shift right.
// Divide (MULDIV_DIV_EN only): restoring shift-subtract, quotient bits enter at bit 0.
// The accumulator holds {upper, lower} = {partial product, multiplier} for multiply
// and {remainder, dividend/quotient} for divide.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    // Multiply step: add multiplicand when the current multiplier bit is set, shift right.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic               fits;
    logic [2*WIDTH-1:0] div_next;

    // Divide step: shift next dividend bit into the remainder, keep the difference if it fits.
    always_comb begin
        trial    = acc[2*WIDTH-1:WIDTH-1];
        fits     = (trial >= {1'b0, opnd});
        diff     = trial - {1'b0, opnd};
        div_next = {(fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), acc[WIDTH-2:0], fits};
        acc_next = is_div ? div_next : mul_next;
    end
`else
    // Without a divider the divide select is never raised; hold the accumulator if it is.
    always_comb begin
        acc_next = is_div ? acc : mul_next;
    end
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// 32 iterations per operation, 33 cycles from start to done.
// Define MULDIV_DIV_EN to include the divider; otherwise DIV/DIVU starts are ignored.
// WIDTH comes from muldiv_pkg; only 32 is supported.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hiWe,
    input  logic             loWe,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(ITER - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     opnd_q;
    logic                 neg_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 done_q;

    op_e                  op_sel;
    logic                 signed_op;
    logic                 accept;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     res_hi, res_lo;
    logic                 step_div;

`ifdef MULDIV_DIV_EN
    logic                 is_div_q;
    logic                 neg_rem_q;
    logic                 dbz_q;
    logic                 dbz_out_q;
    logic [WIDTH-1:0]     quo, rem;
`endif

    // Operand decode and magnitude conversion at launch.
    always_comb begin
        op_sel    = op_e'(op);
        signed_op = (op_sel == OP_MULT) || (op_sel == OP_DIV);
        mag_a     = magnitude(srcA, signed_op);
        mag_b     = magnitude(srcB, signed_op);
`ifdef MULDIV_DIV_EN
        accept    = start && (state_q == StIdle);
        step_div  = is_div_q;
`else
        accept    = start && (state_q == StIdle) && !op[1];
        step_div  = 1'b0;
`endif
    end

    muldiv_step u_step (
        .is_div   (step_div),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (acc_next)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StCalc;
            StCalc:   if (cnt_q == LastIter) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Sign fix-up of the finished accumulator into HI/LO values.
    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        quo    = acc_q[WIDTH-1:0];
        rem    = acc_q[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            // A zero divisor leaves the dividend magnitude in the remainder, so the
            // signed fix-up below returns the original srcA.
            res_lo = dbz_q ? '1 : (neg_q ? -quo : quo);
            res_hi = neg_rem_q ? -rem : rem;
        end
`endif
    end

    // Datapath registers: launch capture, iteration, result write-back and MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            dbz_out_q <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
            dbz_out_q <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        cnt_q <= '0;
                        neg_q <= signed_op && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                        is_div_q  <= op[1];
                        neg_rem_q <= signed_op && srcA[WIDTH-1];
                        dbz_q     <= op[1] && (srcB == '0);
                        if (op[1]) begin
                            acc_q  <= {{WIDTH{1'b0}}, mag_a};
                            opnd_q <= mag_b;
                        end else begin
                            acc_q  <= {{WIDTH{1'b0}}, mag_b};
                            opnd_q <= mag_a;
                        end
`else
                        acc_q  <= {{WIDTH{1'b0}}, mag_b};
                        opnd_q <= mag_a;
`endif
                    end else if (!start) begin
                        if (hiWe) hi_q <= wdata;
                        if (loWe) lo_q <= wdata;
                    end
                end
                StCalc: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                StFinish: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
                    dbz_out_q <= is_div_q && dbz_q;
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MULDIV_DIV_EN
    assign divByZero = dbz_out_q;
`else
    assign divByZero = 1'b0;
`endif

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits downstream of the register file and consumes the two read-port values (rs on Rdata1, rt on Rdata2) for MULT, MULTU, DIV and DIVU. It also services MTHI/MTLO writes and drives HI/LO back to the writeback mux for MFHI/MFLO. While an operation is in flight, the hazard logic stalls any dependent MFHI/MFLO, MTHI/MTLO or new mult/div.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  launches the operation selected by op.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srcA  input  WIDTH  rs value (Rdata1); multiplicand or dividend.
- srcB  input  WIDTH  rt value (Rdata2); multiplier or divisor.
- hiWe  input  1  MTHI write strobe.
- loWe  input  1  MTLO write strobe.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in flight; reset 0.
- done  output  1  one-cycle completion pulse; reset 0.
- divByZero  output  1  qualifies done for a DIV/DIVU with srcB==0; reset 0.
- hi  output  WIDTH  HI register; reset 0.
- lo  output  WIDTH  LO register; reset 0.

## Operation
- FSM states: IDLE, CALC, FINISH.
  - IDLE→CALC on start.
  - CALC→FINISH when the 5-bit iteration counter reaches 31.
  - FINISH→IDLE unconditionally.
- Launch: start is sampled only in IDLE. Operands are captured as magnitudes for MULT/DIV, raw for MULTU/DIVU. Result signs are recorded. The counter is cleared.
- Multiply: 32 shift-add steps on a 64-bit accumulator. In FINISH, the result is negated if the signs differ, then {HI,LO} = product.
- Divide: 32 restoring shift-subtract steps.
  - In FINISH, LO = quotient, truncated toward zero.
  - HI = remainder, carrying the sign of the dividend.
- Divide boundary cases:
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0 gives LO=0xFFFFFFFF, HI=srcA (original value), divByZero=1 with done.
- Ignored events:
  - start while busy=1 is ignored, with no queuing.
  - hiWe/loWe are applied only when busy=0 and start=0; otherwise they are dropped.
  - hiWe and loWe may both be asserted in one cycle; both registers take wdata.
- Reset mid-operation: the next edge with rst_n=0 returns to IDLE, clears HI/LO/busy/done/divByZero and abandons the partial result.

## Timing
- Launch: start=1 sampled in IDLE at edge k sets busy=1 from k+1.
- Iterations occur at edges k+1 … k+32.
- Edge k+33: FINISH writes HI/LO.
  - For the cycle following that edge: done=1, busy=0, and the new hi/lo are visible.
- Latency is 33 cycles from start to done. Throughput is one operation per 34 cycles: the earliest next start is sampled in the done cycle.
- done and divByZero are high for exactly one cycle.
- MTHI/MTLO take effect at the sampling edge and are visible the next cycle.
- hi/lo are registered outputs; they never change during CALC.

## Configuration
- MULDIV_DIV_EN defined: divider datapath present; DIV/DIVU behave as above.
- MULDIV_DIV_EN undefined: no divider logic.
  - start with op[1]=1 is ignored: busy stays 0, no done, HI/LO unchanged.
  - divByZero is tied 0.
  - MULT/MULTU are unchanged.

## Structure
- Shared package muldiv_pkg holds:
  - the op encoding enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the FSM state enum;
  - the constants WIDTH=32 and ITER=32.
- One sub-module: muldiv_step, a combinational single-iteration datapath.
  - Multiply step: add and shift.
  - Divide step: trial subtract, restore and shift.
  - The top level holds the FSM, counter, operand registers and HI/LO.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 → done after 33 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 0x00000002 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 0x00000064 / 0x00000007 → LO=0x0000000E, HI=0x00000002.
- DIVU 0x00000064 / 0 → LO=0xFFFFFFFF, HI=0x00000064, divByZero=1 for exactly the done cycle. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Second start (MULTU 3×3) at cycle 10 of a busy MULT 5×5 → ignored, HI=0, LO=0x19. Start MULTU 3×3 in the done cycle → accepted, LO=0x9 33 cycles later.
- MTHI 0x12345678 in IDLE → hi=0x12345678 next cycle. MTLO issued while busy → dropped, LO holds the operation result.
- Reset asserted at iteration 10 of a DIV → next cycle busy=0, done=0, HI=LO=0. Subsequent MULTU 4×4 → LO=0x10 after 33 cycles.
